// File: rtl/rob_retire_if.sv
// Dispatch/completion/retire bundle for the reorder buffer.
// master: dispatch + FUs drive alloc/cmp; slave: the ROB drives status and retire.
interface rob_retire_if #(
  parameter int IDX_W      = 4,
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int NUM_CMP    = 3
);
  logic                     alloc_valid;
  logic                     alloc_reg_write;
  logic [AREG_WIDTH-1:0]    alloc_arch_rd;
  logic [PREG_WIDTH-1:0]    alloc_rd_new;
  logic [PREG_WIDTH-1:0]    alloc_rd_old;
  logic                     alloc_ready;
  logic [IDX_W-1:0]         alloc_idx;
  logic [NUM_CMP-1:0]       cmp_valid;
  logic [NUM_CMP*IDX_W-1:0] cmp_idx;
  logic                     retire_valid;
  logic [IDX_W-1:0]         retire_idx;
  logic                     push_free_reg;
  logic [PREG_WIDTH-1:0]    freed_reg;
  logic [IDX_W:0]           count;
  logic                     full;
  logic                     empty;

  modport master (
    output alloc_valid, alloc_reg_write, alloc_arch_rd,
    output alloc_rd_new, alloc_rd_old, cmp_valid, cmp_idx,
    input  alloc_ready, alloc_idx, retire_valid, retire_idx,
    input  push_free_reg, freed_reg, count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_reg_write, alloc_arch_rd,
    input  alloc_rd_new, alloc_rd_old, cmp_valid, cmp_idx,
    output alloc_ready, alloc_idx, retire_valid, retire_idx,
    output push_free_reg, freed_reg, count, full, empty
  );
endinterface

// File: rtl/rob_retire.sv
// In-order ROB: allocates at tail, completes by index, retires one per cycle.
// Ports: clk, rst (async, active-high), rob (slave side of rob_retire_if).
module rob_retire #(
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4,
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int NUM_CMP    = 3
) (
  input logic        clk,
  input logic        rst,
  rob_retire_if.slave rob
);

  typedef struct packed {
    logic                  valid;
    logic                  complete;
    logic                  reg_write;
    logic [AREG_WIDTH-1:0] arch_rd;
    logic [PREG_WIDTH-1:0] rd_new;
    logic [PREG_WIDTH-1:0] rd_old;
  } entry_t;

  entry_t                ent_q [DEPTH];
  logic [IDX_W-1:0]      head_q;
  logic [IDX_W-1:0]      tail_q;
  logic [IDX_W:0]        count_q;
  logic                  retire_valid_q;
  logic [IDX_W-1:0]      retire_idx_q;
  logic                  push_q;
  logic [PREG_WIDTH-1:0] freed_q;

  entry_t           head_ent;
  logic             full;
  logic             do_alloc;
  logic             do_retire;
  logic [IDX_W-1:0] cmp_slot [NUM_CMP];

  assign head_ent  = ent_q[head_q];
  assign full      = (count_q == (IDX_W+1)'(DEPTH));
  assign do_alloc  = rob.alloc_valid && !full;
  assign do_retire = head_ent.valid && head_ent.complete;

  always_comb begin
    for (int k = 0; k < NUM_CMP; k++) begin
      cmp_slot[k] = rob.cmp_idx[k*IDX_W +: IDX_W];
    end
  end

  assign rob.alloc_ready   = !full;
  assign rob.alloc_idx     = tail_q;
  assign rob.count         = count_q;
  assign rob.full          = full;
  assign rob.empty         = (count_q == '0);
  assign rob.retire_valid  = retire_valid_q;
  assign rob.retire_idx    = retire_idx_q;
  assign rob.push_free_reg = push_q;
  assign rob.freed_reg     = freed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_idx_q   <= '0;
      push_q         <= 1'b0;
      freed_q        <= '0;
    end else begin
      // Duplicate indices simply set the same bit twice.
      for (int k = 0; k < NUM_CMP; k++) begin
        if (rob.cmp_valid[k] && ent_q[cmp_slot[k]].valid) begin
          ent_q[cmp_slot[k]].complete <= 1'b1;
        end
      end

      if (do_retire) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end

      // Written last so a same-cycle completion on tail loses.
      if (do_alloc) begin
        ent_q[tail_q].valid     <= 1'b1;
        ent_q[tail_q].complete  <= 1'b0;
        ent_q[tail_q].reg_write <= rob.alloc_reg_write;
        ent_q[tail_q].arch_rd   <= rob.alloc_arch_rd;
        ent_q[tail_q].rd_new    <= rob.alloc_rd_new;
        ent_q[tail_q].rd_old    <= rob.alloc_rd_old;
        tail_q                  <= tail_q + 1'b1;
      end

      case ({do_alloc, do_retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      retire_valid_q <= do_retire;
      push_q         <= do_retire && head_ent.reg_write;
      if (do_retire) begin
        retire_idx_q <= head_q;
      end
      // x0 is never remapped, so the tag rename popped for it goes back.
      if (do_retire && head_ent.reg_write) begin
        freed_q <= (head_ent.arch_rd == '0) ? head_ent.rd_new
                                            : head_ent.rd_old;
      end
    end
  end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer that sits downstream of rename/dispatch.
- Dispatch allocates one entry per renamed instruction; the functional units mark entries complete by ROB index.
- Retires the oldest completed instruction, at most one per cycle.
- On retire, returns the superseded physical register to the rename free pool through push_free_reg/freed_reg.

Parameters:
DEPTH, 16, number of ROB entries (power of two)
IDX_W, 4, log2(DEPTH), ROB index width
PREG_WIDTH, 6, physical register tag width
AREG_WIDTH, 5, architectural register index width
NUM_CMP, 3, number of completion ports (one per functional unit)

Ports:
clk  input  1  clock
rst  input  1  reset
alloc_valid  input  1  dispatch requests an entry this cycle
alloc_reg_write  input  1  instruction writes rd (was renamed)
alloc_arch_rd  input  AREG_WIDTH  architectural rd
alloc_rd_new  input  PREG_WIDTH  newly allocated physical tag
alloc_rd_old  input  PREG_WIDTH  previous mapping of rd
alloc_ready  output  1  entry available (= !full)
alloc_idx  output  IDX_W  index given to the allocating instruction (= tail)
cmp_valid  input  NUM_CMP  per-port completion strobe
cmp_idx  input  NUM_CMP*IDX_W  per-port ROB index; port k at [k*IDX_W +: IDX_W]
retire_valid  output  1  registered one-cycle pulse: an entry retired
retire_idx  output  IDX_W  index of the retired entry
push_free_reg  output  1  registered one-cycle pulse to the free pool
freed_reg  output  PREG_WIDTH  tag returned to the free pool
count  output  IDX_W+1  occupied entries
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. Reset clears head, tail, count and every entry's valid/complete bit. Outputs on reset:
  - retire_valid=0, push_free_reg=0, freed_reg=0, retire_idx=0
  - alloc_idx=0, empty=1, full=0, alloc_ready=1
- Reset mid-operation discards all entries. No pushes are issued for discarded entries.
- Entry fields: valid, complete, reg_write, arch_rd, rd_new, rd_old.
- Allocate: condition is alloc_valid && !full at the posedge.
  - Write the entry at tail with valid=1, complete=0.
  - tail <= tail+1, wrapping modulo DEPTH.
  - alloc_valid while full is ignored with no state change. Dispatch must hold its request.
  - alloc_ready uses the registered full. There is no same-cycle bypass from a retire.
- Complete: for each port k with cmp_valid[k], set complete on entry cmp_idx[k] if that entry is valid.
  - A completion on an invalid entry is ignored.
  - Duplicate indices across ports are OR-ed together.
  - If a completion targets the tail slot being allocated in the same cycle, the allocation wins and complete=0.
- Retire: condition at each posedge is that the head entry is valid && complete, using registered complete bits.
  - Clear valid at head; head <= head+1, wrapping.
  - Next cycle: retire_valid=1 and retire_idx=old head.
  - push_free_reg = entry.reg_write.
  - freed_reg = rd_new when arch_rd==0; otherwise rd_old. This is required because x0 is never remapped but rename still pops a tag for it.
  - When reg_write=0: push_free_reg=0 and freed_reg holds its previous value.
  - All pulses last exactly one cycle unless another retire follows back-to-back.
- Latency: a completion sampled at edge N sets complete at N. The retire happens at edge N+1 and the push is visible during cycle N+1→N+2. Minimum alloc→push latency is 3 edges when completion is strobed the cycle after allocation.
- Ordering: completions may arrive in any order. Retirement is strictly in allocation order. A younger completed entry waits behind an older incomplete one.
- Count:
  - Allocate and retire in the same cycle leaves count unchanged; both pointers advance.
  - Allocate only: count+1. Retire only: count-1.
  - full and empty are derived from count.
- Retiring the sole entry while allocating a new one in the same cycle is legal.
- Head == tail with count==DEPTH is full; head == tail with count==0 is empty.

Test Plan:
1. Reset, then idle: empty=1, alloc_ready=1, alloc_idx=0, push_free_reg stays 0 for 10 cycles.
2. Single instruction, then completion on the next cycle:
   - Stimulus: alloc{reg_write=1, rd=5, new=32, old=5}; cmp_valid[0]=1, cmp_idx=0 next cycle.
   - Response: retire_valid/push_free_reg pulse exactly one cycle, 2 cycles after the cmp edge, with freed_reg=5, retire_idx=0.
3. Out-of-order completion:
   - Stimulus: alloc idx 0,1,2 with old tags 7,8,9; complete 2, then 1, then 0 one cycle apart.
   - Response: no push until idx0 completes, then consecutive pulses freed_reg=7,8,9.
4. Full and wrap:
   - Allocate 16 entries with no completions: full=1, alloc_ready=0. A 17th alloc_valid is ignored and count stays 16.
   - Complete idx0: one retire, full drops. Next allocation gets alloc_idx=0 (wrap), and count returns to 16.
5. Special cases:
   - x0 destination: alloc{reg_write=1, arch_rd=0, new=40, old=0} → freed_reg=40 on retire.
   - reg_write=0 entry: retire_valid pulses, push_free_reg stays 0.
6. Reset mid-operation: 5 entries outstanding with 2 complete; assert rst asynchronously between edges → count=0, empty=1 immediately, no push pulses afterward; subsequent alloc_idx=0.
